// File: rtl/mul16_shift_add_if.sv
// rtl/mul16_shift_add_if.sv - start/busy/done handshake bundle for the shift-add multiplier
interface mul16_shift_add_if;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;

   modport master (output start, a, b, input busy, done, product);
   modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mul16_shift_add.sv
// rtl/mul16_shift_add.sv - sequential 16x16->32 unsigned shift-add multiplier on a 16-bit CLA
module cla16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c0,
   output logic [15:0] f,
   output logic        c
);
   logic [15:0] g, p, bc;
   logic [3:0]  gg, gp;
   logic [4:0]  gc;

   assign g = a & b;
   assign p = a ^ b;

   for (genvar k = 0; k < 4; k++) begin : g_grp
      assign gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                   | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      assign gp[k] = &p[4*k +: 4];
      assign bc[4*k]   = gc[k];
      assign bc[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      assign bc[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      assign bc[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                       | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
   end

   // Second lookahead level across the four 4-bit groups
   assign gc[0] = c0;
   assign gc[1] = gg[0] | (gp[0] & c0);
   assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
   assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c0);
   assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
                | (gp[3] & gp[2] & gp[1] & gp[0] & c0);

   assign f = p ^ bc;
   assign c = gc[4];
endmodule

module mul16_shift_add (
   input  logic                 clk,
   input  logic                 rst_n,
   mul16_shift_add_if.slave     bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic [15:0] m, p_hi, p_lo;
   logic [4:0]  cnt;
   logic [31:0] product;
   logic [15:0] add_b, add_f;
   logic        add_c;

   assign add_b = p_lo[0] ? m : 16'h0;

   cla16 u_cla (
      .a  (p_hi),
      .b  (add_b),
      .c0 (1'b0),
      .f  (add_f),
      .c  (add_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         m       <= 16'h0;
         p_hi    <= 16'h0;
         p_lo    <= 16'h0;
         cnt     <= 5'd0;
         product <= 32'h0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  m     <= bus.a;
                  p_hi  <= 16'h0;
                  p_lo  <= bus.b;
                  cnt   <= 5'd0;
                  state <= CALC;
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               // Adder carry-out lands in P_hi[15]; dropping it breaks large products
               {p_hi, p_lo} <= {add_c, add_f, p_lo[15:1]};
               cnt          <= cnt + 5'd1;
               if (cnt == 5'd15) begin
                  product <= {add_c, add_f, p_lo[15:1]};
                  state   <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy    = (state == CALC);
   assign bus.done    = (state == DONE);
   assign bus.product = product;
endmodule

// File: tb/tb_mul16_shift_add.sv
// tb/tb_mul16_shift_add.sv - directed and random checks for mul16_shift_add
module tb_mul16_shift_add;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   done_cnt;
   int   exp_dones;

   mul16_shift_add_if bus ();

   mul16_shift_add dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (bus.done) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int lat, output int busy_n);
      lat    = 0;
      busy_n = 0;
      while (!bus.done && lat < 40) begin
         if (bus.busy) busy_n++;
         step();
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic [31:0] exp_p);
      int lat, busy_n;
      bus.start = 1'b1;
      bus.a     = ia;
      bus.b     = ib;
      step();
      bus.start = 1'b0;
      exp_dones++;
      wait_done(lat, busy_n);
      check({tag, "_lat"}, 32'(lat), 32'd16);
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
      check({tag, "_prod"}, bus.product, exp_p);
      check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      step();
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, "_hold"}, bus.product, exp_p);
   endtask

   initial begin
      int lat, busy_n, n;
      logic [15:0] ra, rb;
      logic [31:0] exp_p;
      checks    = 0;
      errors    = 0;
      done_cnt  = 0;
      exp_dones = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = 16'h0;
      bus.b     = 16'h0;
      step();
      step();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_product", bus.product, 32'h0);
      rst_n = 1'b1;
      step();

      run_op("basic", 16'h0003, 16'h0005, 32'h0000000F);
      run_op("ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
      run_op("carry", 16'h8000, 16'h0002, 32'h00010000);
      run_op("zero", 16'h0000, 16'h1234, 32'h00000000);
      run_op("ident", 16'h1234, 16'h0001, 32'h00001234);

      // start pulse mid-CALC must be ignored
      bus.start = 1'b1; bus.a = 16'h0003; bus.b = 16'h0005;
      step();
      bus.start = 1'b0;
      exp_dones++;
      repeat (3) step();
      bus.start = 1'b1; bus.a = 16'h0002; bus.b = 16'h0002;
      step();
      bus.start = 1'b0;
      wait_done(lat, busy_n);
      check("ign_lat", 32'(lat + 4), 32'd16);
      check("ign_prod", bus.product, 32'h0000000F);
      n = 0;
      repeat (25) begin
         step();
         n += int'(bus.done);
      end
      check("ign_extra_done", 32'(n), 32'd0);
      check("ign_hold", bus.product, 32'h0000000F);

      // asynchronous reset in the middle of a calculation
      bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
      step();
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      check("arst_product", bus.product, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_busy", 32'(bus.busy), 32'd0);
      check("post_rst_done", 32'(bus.done), 32'd0);
      run_op("after_rst", 16'h0007, 16'h0009, 32'h0000003F);

      // back-to-back random pairs with start held high
      ra = 16'($urandom);
      rb = 16'($urandom);
      bus.start = 1'b1; bus.a = ra; bus.b = rb;
      step();
      for (int i = 0; i < 1000; i++) begin
         exp_p = {16'h0, ra} * {16'h0, rb};
         exp_dones++;
         wait_done(lat, busy_n);
         check("b2b_lat", 32'(lat), 32'd16);
         check("b2b_prod", bus.product, exp_p);
         if (i < 999) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            bus.a = ra;
            bus.b = rb;
         end else begin
            bus.start = 1'b0;
         end
         step();
         if (i < 999) begin
            check("b2b_busy", 32'(bus.busy), 32'd1);
            check("b2b_done_fall", 32'(bus.done), 32'd0);
         end
      end
      step();
      check("done_count", 32'(done_cnt), 32'(exp_dones));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
